// File: rtl/bitstream_decoder_if.sv
// Handshake/bus bundle for bitstream_decoder: start/stream in, result out
// behind a valid/ready handshake. The decoder uses the slave modport.
interface bitstream_decoder_if #(
  parameter int WINDOW_LOG2 = 16
);
  logic                 start;
  logic                 stream_in;
  logic                 busy;
  logic [WINDOW_LOG2:0] result;
  logic                 result_valid;
  logic                 result_ready;

  modport master (
    output start,
    output stream_in,
    output result_ready,
    input  busy,
    input  result,
    input  result_valid
  );

  modport slave (
    input  start,
    input  stream_in,
    input  result_ready,
    output busy,
    output result,
    output result_valid
  );
endinterface

// File: rtl/bitstream_decoder.sv
// Counts ones of a stochastic bitstream over 2^WINDOW_LOG2 cycles after SKIP
// warm-up cycles. Optional macro BITSTREAM_DECODER_SATURATE_EN clamps result.
module bitstream_decoder #(
  parameter int WINDOW_LOG2 = 16,
  parameter int SKIP        = 0
) (
  input  logic                clk,
  input  logic                n_rst,
  bitstream_decoder_if.slave  bus
);

  localparam int AW = WINDOW_LOG2 + 1;
  localparam logic [7:0] SKIP_LOAD = (SKIP > 0) ? 8'(SKIP - 1) : 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_COUNT,
    ST_HOLD
  } state_e;

  state_e                 state_q, state_d;
  state_e                 start_st;
  logic [AW-1:0]          acc_q, acc_d;
  logic [WINDOW_LOG2-1:0] win_q, win_d;
  logic [7:0]             skip_q, skip_d;
  logic [AW-1:0]          result_q, result_d;

  logic                   accept;
  logic                   win_last;
  logic [AW-1:0]          acc_sum;
  logic [AW-1:0]          result_final;

  // A start is honoured in IDLE, or in HOLD only on the handshake cycle.
  always_comb begin
    accept   = bus.start &&
               ((state_q == ST_IDLE) ||
                ((state_q == ST_HOLD) && bus.result_ready));
    start_st = (SKIP > 0) ? ST_SKIP : ST_COUNT;
    win_last = &win_q;
    acc_sum  = acc_q + AW'(bus.stream_in);
  end

  always_comb begin
`ifdef BITSTREAM_DECODER_SATURATE_EN
    result_final = acc_sum[AW-1] ? {1'b0, {WINDOW_LOG2{1'b1}}} : acc_sum;
`else
    result_final = acc_sum;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = start_st;
      ST_SKIP:  if (skip_q == 8'd0) state_d = ST_COUNT;
      ST_COUNT: if (win_last) state_d = ST_HOLD;
      ST_HOLD: begin
        if (bus.result_ready) state_d = accept ? start_st : ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_q    <= '0;
      win_q    <= '0;
      skip_q   <= '0;
      result_q <= '0;
    end else begin
      acc_q    <= acc_d;
      win_q    <= win_d;
      skip_q   <= skip_d;
      result_q <= result_d;
    end
  end

  // result_q only moves on the final sample, so it survives the handshake.
  always_comb begin
    acc_d    = acc_q;
    win_d    = win_q;
    skip_d   = skip_q;
    result_d = result_q;
    if (accept) begin
      acc_d  = '0;
      win_d  = '0;
      skip_d = SKIP_LOAD;
    end else begin
      case (state_q)
        ST_SKIP: begin
          if (skip_q != 8'd0) skip_d = skip_q - 8'd1;
        end
        ST_COUNT: begin
          acc_d = acc_sum;
          win_d = win_q + WINDOW_LOG2'(1);
          if (win_last) result_d = result_final;
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    bus.busy         = (state_q == ST_SKIP) || (state_q == ST_COUNT);
    bus.result_valid = (state_q == ST_HOLD);
    bus.result       = result_q;
  end

endmodule
